// File: rtl/sync_fifo_ctrl_if.sv
// Handshake/status bundle between a single-clock FIFO controller and its user.
// The master modport is the producer/consumer side; the slave modport is the FIFO.
interface sync_fifo_ctrl_if #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4
);
    logic                 wr_en;
    logic [DATA_SIZE-1:0] wdata;
    logic                 rd_en;
    logic                 err_clr;
    logic [DATA_SIZE-1:0] rdata;
    logic                 rvalid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDR_SIZE:0]   count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output wr_en, wdata, rd_en, err_clr,
        input  rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wdata, rd_en, err_clr,
        output rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: dual-port storage, wrap-bit pointers, occupancy count,
// status flags decoded from the count, and sticky overflow/underflow errors.
module sync_fifo_ctrl #(
    parameter int DATA_SIZE     = 8,
    parameter int ADDR_SIZE     = 4,
    parameter int AFULL_THRESH  = (1 << ADDR_SIZE) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input logic            clk,
    input logic            rst,
    sync_fifo_ctrl_if.slave bus
);
    localparam int                 DEPTH   = 1 << ADDR_SIZE;
    localparam int                 CNT_W   = ADDR_SIZE + 1;
    localparam logic [CNT_W-1:0]   PTR_INC = CNT_W'(1);

    logic [DATA_SIZE-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0]     wptr_r;
    logic [CNT_W-1:0]     rptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [DATA_SIZE-1:0] rdata_r;
    logic                 rvalid_r;
    logic                 overflow_r;
    logic                 underflow_r;

    logic                 empty_s;
    logic                 full_s;
    logic                 rd_acc_s;
    logic                 wr_acc_s;
    logic                 ovf_set_s;
    logic                 udf_set_s;
    logic [CNT_W-1:0]     count_nxt_s;

    assign empty_s = (count_r == CNT_W'(0));
    assign full_s  = (count_r == CNT_W'(DEPTH));

    // Acceptance decisions; a write into a full FIFO is allowed only alongside an accepted read.
    always_comb begin
        rd_acc_s    = 1'b0;
        wr_acc_s    = 1'b0;
        ovf_set_s   = 1'b0;
        udf_set_s   = 1'b0;
        count_nxt_s = count_r;
        if (rst) begin
            rd_acc_s = 1'b0;
            wr_acc_s = 1'b0;
        end else begin
            rd_acc_s    = bus.rd_en && !empty_s;
            wr_acc_s    = bus.wr_en && (!full_s || rd_acc_s);
            ovf_set_s   = bus.wr_en && !wr_acc_s;
            udf_set_s   = bus.rd_en && !rd_acc_s;
            count_nxt_s = count_r + CNT_W'(wr_acc_s) - CNT_W'(rd_acc_s);
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wptr_r[ADDR_SIZE-1:0]] <= bus.wdata;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r   <= CNT_W'(0);
            rptr_r   <= CNT_W'(0);
            count_r  <= CNT_W'(0);
            rdata_r  <= DATA_SIZE'(0);
            rvalid_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (wr_acc_s) begin
                wptr_r <= wptr_r + PTR_INC;
            end
            if (rd_acc_s) begin
                rdata_r  <= mem_r[rptr_r[ADDR_SIZE-1:0]];
                rptr_r   <= rptr_r + PTR_INC;
                rvalid_r <= 1'b1;
            end else begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_r <= 1'b0;
            end
            if (udf_set_s) begin
                underflow_r <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_r <= 1'b0;
            end
        end
    end

    assign bus.rdata        = rdata_r;
    assign bus.rvalid       = rvalid_r;
    assign bus.count        = count_r;
    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.almost_full  = (count_r >= CNT_W'(AFULL_THRESH));
    assign bus.almost_empty = (count_r <= CNT_W'(AEMPTY_THRESH));
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
endmodule
